// File: rtl/racer_motion_ctrl.sv
// racer_motion_ctrl: frame-synchronous player car motion controller (speed, position, distance, crash stun)
// Ports: pclk/rst_n (async active-low reset), frame_ended_in (end-of-frame pulse), enable (game running),
//        btn_left/btn_right/btn_accel/btn_brake (controls), crash_in (collision),
//        xpos/ypos (sprite corner), speed, distance, stunned.
// Build option: define RACER_CTRL_WRAP_EN to wrap xpos at the edges instead of clamping.
module racer_motion_ctrl #(
  parameter int X_INIT      = 448,
  parameter int X_MIN       = 0,
  parameter int X_MAX       = 896,
  parameter int Y_BASE      = 600,
  parameter int STEER_STEP  = 4,
  parameter int SPEED_MAX   = 15,
  parameter int STUN_FRAMES = 60
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        frame_ended_in,
  input  logic        enable,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_accel,
  input  logic        btn_brake,
  input  logic        crash_in,
  output logic [10:0] xpos,
  output logic [10:0] ypos,
  output logic [3:0]  speed,
  output logic [15:0] distance,
  output logic        stunned
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STUN = 2'd2;
  localparam logic signed [11:0] XMIN = 12'(X_MIN);
  localparam logic signed [11:0] XMAX = 12'(X_MAX);
  localparam logic signed [11:0] SPAN = 12'(X_MAX - X_MIN + 1);
  localparam logic signed [11:0] STEP = 12'(STEER_STEP);
  logic [1:0] state, state_n;
  // {crash, brake, accel, right, left}; ev folds in the current cycle so a press on the pulse cycle still counts
  logic [4:0] lat, ev;
  logic [7:0] cnt, cnt_n;
  logic [1:0] dec, dec_inc, dec_n;
  logic [3:0] spd, sp_n;
  logic signed [11:0] step, xt, xb;
  logic [10:0] x_n, y_n;
  logic [15:0] d_n;
  logic st_n;
  assign ev = lat | {crash_in, btn_brake, btn_accel, btn_right, btn_left};
  assign dec_inc = dec + 2'd1;
  always_comb begin
    spd = ev[3] ? (speed < 4'd2 ? 4'd0 : speed - 4'd2)
        : ev[2] ? (speed >= 4'(SPEED_MAX) ? 4'(SPEED_MAX) : speed + 4'd1)
        : (dec_inc == 2'd0 && speed != 4'd0) ? speed - 4'd1 : speed;
    step = (spd == 4'd0 || ev[0] == ev[1]) ? 12'sd0 : ev[1] ? STEP : -STEP;
    xt = $signed({1'b0, xpos}) + step;
`ifdef RACER_CTRL_WRAP_EN
    xb = xt < XMIN ? xt + SPAN : xt > XMAX ? xt - SPAN : xt;
`else
    xb = xt < XMIN ? XMIN : xt > XMAX ? XMAX : xt;
`endif
  end
  always_comb begin
    state_n = state;
    x_n = xpos;
    y_n = 11'(Y_BASE);
    sp_n = 4'd0;
    d_n = distance;
    st_n = stunned;
    cnt_n = cnt;
    dec_n = dec;
    if (!enable || state == IDLE) begin
      x_n = 11'(X_INIT);
      st_n = 1'b0;
      cnt_n = 8'd0;
      dec_n = 2'd0;
      state_n = (state == IDLE && enable) ? RUN : IDLE;
    end else if (state == STUN) begin
      state_n = cnt == 8'd0 ? RUN : STUN;
      st_n = cnt != 8'd0;
      cnt_n = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
    end else if (ev[4]) begin
      cnt_n = 8'(STUN_FRAMES - 1);
      st_n = 1'b1;
      state_n = STUN;
    end else begin
      sp_n = spd;
      y_n = 11'(Y_BASE) - {5'd0, spd, 2'b00};
      x_n = xb[10:0];
      d_n = distance + {12'd0, spd};
      dec_n = (ev[3] | ev[2]) ? dec : dec_inc;
    end
  end
  always_ff @(posedge pclk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lat <= '0;
      xpos <= 11'(X_INIT);
      ypos <= 11'(Y_BASE);
      speed <= '0;
      distance <= '0;
      stunned <= 1'b0;
      cnt <= '0;
      dec <= '0;
    end else begin
      lat <= frame_ended_in ? 5'd0 : ev;
      if (frame_ended_in) begin
        state <= state_n;
        xpos <= x_n;
        ypos <= y_n;
        speed <= sp_n;
        distance <= d_n;
        stunned <= st_n;
        cnt <= cnt_n;
        dec <= dec_n;
      end
    end
endmodule
